// File: rtl/udp_synapse_loader_if.sv
// -----------------------------------------------------------------------------
// udp_synapse_loader_if
// Bundles the two data paths of the synapse loader: the read side of the UDP
// receive FIFO and the write port of the synapse SRAM.
//   fifo_empty     FIFO has no word available
//   fifo_read      read strobe, one word per cycle
//   fifo_data_out  FIFO word, valid the cycle after fifo_read
//   sram_we        SRAM write enable
//   sram_addr      SRAM word address {row, word}
//   sram_wdata     SRAM write data
// Modports: master = loader side, slave = FIFO/SRAM side.
// -----------------------------------------------------------------------------
interface udp_synapse_loader_if #(
  parameter int SYNAPSE_DATA_WIDTH = 32,
  parameter int ADDR_W             = 17
) ();
  logic                          fifo_empty;
  logic                          fifo_read;
  logic [SYNAPSE_DATA_WIDTH-1:0] fifo_data_out;
  logic                          sram_we;
  logic [ADDR_W-1:0]             sram_addr;
  logic [SYNAPSE_DATA_WIDTH-1:0] sram_wdata;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    output fifo_read,
    output sram_we,
    output sram_addr,
    output sram_wdata
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    input  fifo_read,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata
  );
endinterface

// File: rtl/udp_synapse_loader.sv
// -----------------------------------------------------------------------------
// udp_synapse_loader
// On each rising edge of frame_ready, reads exactly HANG_LEN words from the UDP
// receive FIFO and writes them as one row of the synapse SRAM. The row pointer
// advances once per completed frame and wraps after 2^ROW_W rows.
// Ports:
//   hclk                 clock
//   write_fifo_full_clr  asynchronous active-high reset
//   frame_ready          level input; a rising edge seen in IDLE starts a load
//   bus                  FIFO read side + SRAM write port (master modport)
//   load_busy            high from start until the DONE state exits
//   load_done            one-cycle pulse, one cycle after the last SRAM write
//   row_idx              row the current or next frame writes to
//   frame_checksum       (LOADER_CHECKSUM_EN only) mod-2^32 sum of the frame
// Build option: define LOADER_CHECKSUM_EN to add the frame_checksum output.
// -----------------------------------------------------------------------------
module udp_synapse_loader #(
  parameter int SYNAPSE_DATA_WIDTH = 32,
  parameter int HANG_LEN           = 256,
  parameter int HANG_LEN_B         = 8,
  parameter int ROW_W              = 9
) (
  input  logic                          hclk,
  input  logic                          write_fifo_full_clr,
  input  logic                          frame_ready,
  udp_synapse_loader_if.master          bus,
  output logic                          load_busy,
  output logic                          load_done,
  output logic [ROW_W-1:0]              row_idx
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [SYNAPSE_DATA_WIDTH-1:0] frame_checksum
`endif
);

  // rd_cnt must be able to hold HANG_LEN itself, hence one extra bit.
  localparam int CNT_W = HANG_LEN_B + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HANG_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  logic                            r_frame_ready_d;
  logic [CNT_W-1:0]                r_rd_cnt;
  logic                            r_rd_pending;
  logic [HANG_LEN_B-1:0]           r_wr_idx;
  logic [ROW_W-1:0]                r_row_idx;
  logic                            r_load_busy;
  logic                            r_load_done;
  logic                            r_sram_we;
  logic [ROW_W+HANG_LEN_B-1:0]     r_sram_addr;
  logic [SYNAPSE_DATA_WIDTH-1:0]   r_sram_wdata;

  logic                            w_start;
  logic                            w_fifo_read;

  assign w_start = frame_ready & ~r_frame_ready_d;

  // Read strobe: issued straight from fifo_empty so an empty FIFO is never read.
  always_comb begin
    w_fifo_read = 1'b0;
    if ((r_state == S_READ) && !bus.fifo_empty && (r_rd_cnt < LAST_CNT)) begin
      w_fifo_read = 1'b1;
    end else begin
      w_fifo_read = 1'b0;
    end
  end

  // frame_ready history for rising-edge detection.
  always_ff @(posedge hclk or posedge write_fifo_full_clr) begin
    if (write_fifo_full_clr) begin
      r_frame_ready_d <= 1'b0;
    end else begin
      r_frame_ready_d <= frame_ready;
    end
  end

  // Frame control FSM with its registered status outputs.
  always_ff @(posedge hclk or posedge write_fifo_full_clr) begin
    if (write_fifo_full_clr) begin
      r_state     <= S_IDLE;
      r_rd_cnt    <= '0;
      r_row_idx   <= '0;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_load_done <= 1'b0;
          if (w_start) begin
            r_state     <= S_READ;
            r_rd_cnt    <= '0;
            r_load_busy <= 1'b1;
          end
        end
        S_READ: begin
          if (w_fifo_read) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
          end
          if (r_rd_cnt == LAST_CNT) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Wait for the last word still in the read pipeline to be written.
          if (!r_rd_pending) begin
            r_state     <= S_DONE;
            r_load_done <= 1'b1;
            r_row_idx   <= r_row_idx + ROW_W'(1);
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_load_done <= 1'b0;
          r_load_busy <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_load_done <= 1'b0;
          r_load_busy <= 1'b0;
        end
      endcase
    end
  end

  // Write pipeline: a read at N gives data at N+1 and a registered write at N+2.
  always_ff @(posedge hclk or posedge write_fifo_full_clr) begin
    if (write_fifo_full_clr) begin
      r_rd_pending <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_wr_idx     <= '0;
    end else begin
      r_rd_pending <= w_fifo_read;
      r_sram_we    <= r_rd_pending;
      if (r_rd_pending) begin
        r_sram_addr  <= {r_row_idx, r_wr_idx};
        r_sram_wdata <= bus.fifo_data_out;
        r_wr_idx     <= r_wr_idx + HANG_LEN_B'(1);
      end else if ((r_state == S_IDLE) && w_start) begin
        r_wr_idx <= '0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [SYNAPSE_DATA_WIDTH-1:0] r_checksum;

  // Running sum of written words; cleared on an accepted start.
  always_ff @(posedge hclk or posedge write_fifo_full_clr) begin
    if (write_fifo_full_clr) begin
      r_checksum <= '0;
    end else if (r_rd_pending) begin
      r_checksum <= r_checksum + bus.fifo_data_out;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_checksum <= '0;
    end
  end

  assign frame_checksum = r_checksum;
`endif

  assign bus.fifo_read  = w_fifo_read;
  assign bus.sram_we    = r_sram_we;
  assign bus.sram_addr  = r_sram_addr;
  assign bus.sram_wdata = r_sram_wdata;
  assign load_busy      = r_load_busy;
  assign load_done      = r_load_done;
  assign row_idx        = r_row_idx;

endmodule

// File: tb/tb_udp_synapse_loader.sv
module tb_udp_synapse_loader;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic rst = 1'b1;
  logic frame_ready = 1'b0;
  logic load_busy, load_done;
  logic [8:0] row_idx;

  // Main DUT: default geometry
  udp_synapse_loader_if #(.SYNAPSE_DATA_WIDTH(32), .ADDR_W(17)) bus ();

  logic [31:0] mem [0:4095];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic        flush  = 1'b0;
  logic [31:0] fifo_q = 32'h0;

  assign bus.fifo_empty    = (rd_ptr == wr_ptr);
  assign bus.fifo_data_out = fifo_q;

  // Behavioural FIFO: data appears the cycle after the read strobe
  always @(posedge hclk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_read) begin
      fifo_q <= mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] frame_checksum;
  logic [31:0] frame_checksum2;
`endif

  udp_synapse_loader dut (
    .hclk(hclk), .write_fifo_full_clr(rst), .frame_ready(frame_ready),
    .bus(bus), .load_busy(load_busy), .load_done(load_done), .row_idx(row_idx)
`ifdef LOADER_CHECKSUM_EN
    , .frame_checksum(frame_checksum)
`endif
  );

  // Second DUT with short rows, used for the 512-row wrap
  udp_synapse_loader_if #(.SYNAPSE_DATA_WIDTH(32), .ADDR_W(11)) bus2 ();
  logic frame_ready2 = 1'b0;
  logic load_busy2, load_done2;
  logic [8:0] row_idx2;
  assign bus2.fifo_empty    = 1'b0;
  assign bus2.fifo_data_out = 32'h0000_0000;

  udp_synapse_loader #(.SYNAPSE_DATA_WIDTH(32), .HANG_LEN(4), .HANG_LEN_B(2), .ROW_W(9)) dut2 (
    .hclk(hclk), .write_fifo_full_clr(rst), .frame_ready(frame_ready2),
    .bus(bus2), .load_busy(load_busy2), .load_done(load_done2), .row_idx(row_idx2)
`ifdef LOADER_CHECKSUM_EN
    , .frame_checksum(frame_checksum2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  int n_reads = 0, n_writes = 0, n_dones = 0;
  int m_row = 0, m_word = 0, m_fw = 0;
  logic prev_we = 1'b0;
  logic [23:0] cur_tag = 24'h0;
  logic exp_const_en = 1'b0;
  logic [31:0] exp_const = 32'h0;

  typedef struct {
    string       name;
    int          pre;
    int          stall;
    int          post;
    bit          retoggle;
    logic [23:0] tag;
    int          exp_reads;
    int          exp_writes;
    int          exp_row;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic push(input int n, input logic [23:0] tag, input int start);
    for (int i = 0; i < n; i++) begin
      logic [7:0] idx;
      idx = 8'(start + i);
      mem[wr_ptr[11:0]] = exp_const_en ? exp_const : {tag, idx};
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic wait_dones(input int target, input string nm);
    for (int c = 0; c < 3000 && n_dones < target; c++) tick();
    check(nm, 64'(n_dones >= target), 64'd1);
  endtask

  // Independent model of the SRAM write stream of the main DUT
  task automatic monitor();
    forever begin
      @(negedge hclk);
      if (rst) begin
        m_row = 0; m_word = 0; m_fw = 0; prev_we = 1'b0;
      end else begin
        if (bus.fifo_read) begin
          n_reads++;
          check("read_while_empty", 64'(bus.fifo_empty), 64'd0);
        end
        if (bus.sram_we) begin
          logic [16:0] ea;
          logic [7:0]  w8;
          n_writes++;
          w8 = 8'(m_word);
          ea = {9'(m_row), w8};
          check("sram_addr", 64'(bus.sram_addr), 64'(ea));
          check("sram_wdata", 64'(bus.sram_wdata), exp_const_en ? 64'(exp_const) : 64'({cur_tag, w8}));
          m_word++; m_fw++;
        end
        if (load_done) begin
          n_dones++;
          check("done_after_last_we", 64'({prev_we, bus.sram_we}), 64'b10);
          check("frame_writes", 64'(m_fw), 64'd256);
          m_row = (m_row + 1) % 512;
          check("row_idx_at_done", 64'(row_idx), 64'(m_row));
          m_fw = 0; m_word = 0;
        end
        prev_we = bus.sram_we;
      end
    end
  endtask

  initial begin
    int base_r, base_w, base_d;
    int cnt;
    bit done_seen;
    logic [10:0] addrs [4];

    vecs[0] = '{"plain",    256, 0,  0,   1'b0, 24'h000000, 256, 256, 1};
    vecs[1] = '{"stall",    100, 20, 156, 1'b0, 24'h0A0B0C, 256, 256, 2};
    vecs[2] = '{"retoggle", 256, 0,  0,   1'b1, 24'h123456, 256, 256, 3};
    vecs[3] = '{"overfull", 300, 0,  0,   1'b0, 24'hBEEF00, 256, 256, 4};

    fork monitor(); join_none

    // Reset state
    repeat (3) tick();
    check("rst_sram_we",   64'(bus.sram_we), 64'd0);
    check("rst_sram_addr", 64'(bus.sram_addr), 64'd0);
    check("rst_sram_wdata",64'(bus.sram_wdata), 64'd0);
    check("rst_fifo_read", 64'(bus.fifo_read), 64'd0);
    check("rst_busy",      64'(load_busy), 64'd0);
    check("rst_done",      64'(load_done), 64'd0);
    check("rst_row",       64'(row_idx), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      base_r = n_reads; base_w = n_writes; base_d = n_dones;
      cur_tag = vecs[v].tag;
      push(vecs[v].pre, vecs[v].tag, 0);
      frame_ready = 1'b1;
      tick(); tick();
      check({vecs[v].name, "_busy"}, 64'(load_busy), 64'd1);
      if (vecs[v].retoggle) begin
        repeat (10) tick();
        frame_ready = 1'b0;
        tick();
        frame_ready = 1'b1;
        tick();
      end
      if (vecs[v].stall > 0) begin
        for (int c = 0; c < 500 && (n_reads - base_r) < vecs[v].pre; c++) tick();
        repeat (vecs[v].stall) tick();
        check({vecs[v].name, "_stall_reads"},  64'(n_reads - base_r), 64'(vecs[v].pre));
        check({vecs[v].name, "_stall_writes"}, 64'(n_writes - base_w), 64'(vecs[v].pre));
        check({vecs[v].name, "_stall_rd_low"}, 64'(bus.fifo_read), 64'd0);
        check({vecs[v].name, "_stall_busy"},   64'(load_busy), 64'd1);
        push(vecs[v].post, vecs[v].tag, vecs[v].pre);
      end
      wait_dones(base_d + 1, {vecs[v].name, "_done_timeout"});
      if (vecs[v].retoggle) begin
        push(8, vecs[v].tag, 0);
        repeat (20) tick();
        check({vecs[v].name, "_no_restart"}, 64'(n_reads - base_r), 64'd256);
      end
      frame_ready = 1'b0;
      repeat (4) tick();
      check({vecs[v].name, "_reads"},  64'(n_reads - base_r),  64'(vecs[v].exp_reads));
      check({vecs[v].name, "_writes"}, 64'(n_writes - base_w), 64'(vecs[v].exp_writes));
      check({vecs[v].name, "_dones"},  64'(n_dones - base_d),  64'd1);
      check({vecs[v].name, "_row"},    64'(row_idx),           64'(vecs[v].exp_row));
      check({vecs[v].name, "_idle"},   64'(load_busy),         64'd0);
      do_flush();
    end

    // Reset mid-frame at word 50
    base_r = n_reads; base_d = n_dones;
    cur_tag = 24'h55AA55;
    push(256, cur_tag, 0);
    frame_ready = 1'b1;
    for (int c = 0; c < 500 && (n_reads - base_r) < 50; c++) tick();
    check("midrst_reached", 64'((n_reads - base_r) >= 50), 64'd1);
    rst = 1'b1;
    frame_ready = 1'b0;
    tick();
    check("midrst_fifo_read", 64'(bus.fifo_read), 64'd0);
    check("midrst_sram_we",   64'(bus.sram_we),   64'd0);
    check("midrst_row",       64'(row_idx),       64'd0);
    check("midrst_busy",      64'(load_busy),     64'd0);
    tick();
    rst = 1'b0;
    base_r = n_reads; base_w = n_writes;
    repeat (300) tick();
    check("midrst_no_reads",  64'(n_reads - base_r),  64'd0);
    check("midrst_no_writes", 64'(n_writes - base_w), 64'd0);
    check("midrst_no_done",   64'(n_dones - base_d),  64'd0);
    check("midrst_row_hold",  64'(row_idx),           64'd0);
    do_flush();

`ifdef LOADER_CHECKSUM_EN
    // All-ones frame: 256 * 0xFFFFFFFF mod 2^32
    base_d = n_dones;
    exp_const_en = 1'b1;
    exp_const = 32'hFFFF_FFFF;
    push(256, 24'h0, 0);
    frame_ready = 1'b1;
    for (int c = 0; c < 3000 && n_dones == base_d; c++) tick();
    check("cks_value", 64'(frame_checksum), 64'hFFFF_FF00);
    frame_ready = 1'b0;
    repeat (4) tick();
    check("cks_hold", 64'(frame_checksum), 64'hFFFF_FF00);
    exp_const_en = 1'b0;
    do_flush();
`endif

    // Row wrap on the short-row instance
    for (int f = 0; f < 513; f++) begin
      cnt = 0;
      done_seen = 1'b0;
      frame_ready2 = 1'b1;
      for (int c = 0; c < 40 && !done_seen; c++) begin
        tick();
        if (bus2.sram_we) begin
          if (cnt < 4) addrs[cnt] = bus2.sram_addr;
          cnt++;
        end
        if (load_done2) done_seen = 1'b1;
      end
      if (!done_seen) check("wrap_timeout", 64'(f), 64'hFFFF);
      frame_ready2 = 1'b0;
      tick();
      if (f == 510) check("wrap_row_511", 64'(row_idx2), 64'd511);
      if (f == 511) begin
        check("wrap_f511_cnt",  64'(cnt), 64'd4);
        check("wrap_f511_a0",   64'(addrs[0]), 64'h7FC);
        check("wrap_f511_a3",   64'(addrs[3]), 64'h7FF);
        check("wrap_row_0",     64'(row_idx2), 64'd0);
      end
      if (f == 512) begin
        check("wrap_f512_cnt",  64'(cnt), 64'd4);
        check("wrap_f512_a0",   64'(addrs[0]), 64'h000);
        check("wrap_f512_a1",   64'(addrs[1]), 64'h001);
        check("wrap_f512_a3",   64'(addrs[3]), 64'h003);
        check("wrap_row_1",     64'(row_idx2), 64'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
